// File: rtl/mdu_ctrl_if.sv
// E-stage to MDU handshake bundle.
// Carries the op request, the D-stage HI/LO use flag and the MDU status/results.
interface mdu_ctrl_if;
  logic        Estart;
  logic [2:0]  Eop;
  logic [31:0] Ea;
  logic [31:0] Eb;
  logic        Dmd_use;
  logic        busy;
  logic        Dstall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output Estart, Eop, Ea, Eb, Dmd_use,
    input  busy, Dstall, hi, lo
  );

  modport slave (
    input  Estart, Eop, Ea, Eb, Dmd_use,
    output busy, Dstall, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers.
// Result is computed at start, held for a fixed latency, then committed.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic     clk,
  input logic     rst_n,
  mdu_ctrl_if.slave m
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, nstate;

  logic [CW-1:0] cnt;
  logic [31:0]   phi, plo;
  logic          pwr;
  logic [31:0]   hi_q, lo_q;

  logic          idle, go, done, isdiv, bzero;
  logic          mthi, mtlo;

  logic signed [63:0] smul;
  logic [63:0]        umul;
  logic signed [32:0] sa, sb, sq, sr;
  logic [31:0]        ub, uq, ur;
  logic [63:0]        res;

  assign idle  = (state == IDLE);
  assign go    = idle & m.Estart & ~m.Eop[2];
  assign done  = (state == RUN) & (cnt == CW'(1));
  assign isdiv = m.Eop[1];
  assign bzero = (m.Eb == 32'd0);
  assign mthi  = idle & m.Estart & (m.Eop == 3'd4);
  assign mtlo  = idle & m.Estart & (m.Eop == 3'd5);

  // Divisor forced to 1 on zero so the divider never sees x/0;
  // the result is discarded at commit in that case.
  always_comb begin
    ub   = bzero ? 32'd1 : m.Eb;
    sa   = {m.Ea[31], m.Ea};
    sb   = bzero ? 33'sd1 : {m.Eb[31], m.Eb};
    smul = $signed({{32{m.Ea[31]}}, m.Ea})
         * $signed({{32{m.Eb[31]}}, m.Eb});
    umul = {32'd0, m.Ea} * {32'd0, m.Eb};
    sq   = sa / sb;
    sr   = sa % sb;
    uq   = m.Ea / ub;
    ur   = m.Ea % ub;
  end

  always_comb begin
    res = 64'd0;
    unique case (1'b1)
      (m.Eop == 3'd0): res = smul;
      (m.Eop == 3'd1): res = umul;
      (m.Eop == 3'd2): res = {sr[31:0], sq[31:0]};
      (m.Eop == 3'd3): res = {ur, uq};
      default:         res = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (go)   nstate = RUN;
      RUN:     if (done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    m.busy   = (state == RUN);
    m.Dstall = m.Dmd_use & ((state == RUN) | (m.Estart & ~m.Eop[2]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      phi  <= '0;
      plo  <= '0;
      pwr  <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (go) begin
        phi <= res[63:32];
        plo <= res[31:0];
        pwr <= ~(isdiv & bzero);
        cnt <= isdiv ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        if (done && pwr) begin
          hi_q <= phi;
          lo_q <= plo;
        end
      end
      if (mthi) hi_q <= m.Ea;
      if (mtlo) lo_q <= m.Ea;
    end
  end

  assign m.hi = hi_q;
  assign m.lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mdu_ctrl_if m();

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .m(m)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    longint sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; cyc = 5; end
      3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; cyc = 5; end
      3'd2: begin
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        cyc = 10;
      end
      3'd3: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        cyc = 10;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dmd,
                        output int cyc, output int sbad);
    @(negedge clk);
    m.Estart = 1'b1; m.Eop = op; m.Ea = a; m.Eb = b; m.Dmd_use = dmd;
    #1;
    sbad = 0;
    if (m.Dstall !== (dmd && (op <= 3'd3))) sbad++;
    @(negedge clk);
    m.Estart = 1'b0;
    #1;
    cyc = 0;
    while (m.busy === 1'b1 && cyc < 200) begin
      if (m.Dstall !== dmd) sbad++;
      cyc++;
      @(negedge clk);
      #1;
    end
    if (m.Dstall !== 1'b0) sbad++;
  endtask

  vec_t tbl[11];
  int cyc, sbad, mcyc;

  initial begin
    m.Estart = 1'b0; m.Eop = 3'd0; m.Ea = '0; m.Eb = '0; m.Dmd_use = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", m.busy, 0);
    check("rst_hi", m.hi, 0);
    check("rst_lo", m.lo, 0);
    check("rst_dstall", m.Dstall, 0);
    rst_n = 1'b1;

    tbl[0]  = '{3'd4, 32'h11,       32'h0,        32'h11,       32'h0,        0};
    tbl[1]  = '{3'd5, 32'h22,       32'h0,        32'h11,       32'h22,       0};
    tbl[2]  = '{3'd3, 32'd7,        32'd0,        32'h11,       32'h22,       10};
    tbl[3]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    tbl[4]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 5};
    tbl[5]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    tbl[7]  = '{3'd6, 32'h123,      32'h5,        32'h0,        32'h80000000, 0};
    tbl[8]  = '{3'd4, 32'hABCD,     32'h0,        32'hABCD,     32'h80000000, 0};
    tbl[9]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    tbl[10] = '{3'd0, 32'd3,        32'd4,        32'd0,        32'd12,       5};

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, cyc, sbad);
      check($sformatf("tbl%0d_cyc", i), cyc, tbl[i].ecyc);
      check($sformatf("tbl%0d_hi", i), m.hi, tbl[i].ehi);
      check($sformatf("tbl%0d_lo", i), m.lo, tbl[i].elo);
      check($sformatf("tbl%0d_stall", i), sbad, 0);
    end

    // Reset on the 2nd busy cycle discards the in-flight result.
    @(negedge clk);
    m.Estart = 1'b1; m.Eop = 3'd0; m.Ea = 32'd3; m.Eb = 32'd4;
    @(negedge clk);
    m.Estart = 1'b0;
    @(negedge clk);
    #1;
    check("midrun_busy_pre", m.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_busy", m.busy, 0);
    check("midrun_hi", m.hi, 0);
    check("midrun_lo", m.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("postrst_busy", m.busy, 0);
    check("postrst_hi", m.hi, 0);
    check("postrst_lo", m.lo, 0);

    // No D-stage HI/LO user means no stall at all.
    run_op(3'd0, 32'd9, 32'd9, 1'b0, cyc, sbad);
    check("nouse_stall", sbad, 0);
    check("nouse_lo", m.lo, 81);

    // MTLO pulse during RUN is ignored.
    @(negedge clk);
    m.Estart = 1'b1; m.Eop = 3'd0; m.Ea = 32'd6; m.Eb = 32'd7;
    @(negedge clk);
    m.Estart = 1'b0;
    @(negedge clk);
    m.Estart = 1'b1; m.Eop = 3'd5; m.Ea = 32'h5;
    @(negedge clk);
    m.Estart = 1'b0;
    #1;
    check("ign_lo_mid", m.lo, 81);
    cyc = 2;
    while (m.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("ign_cyc", cyc, 5);
    check("ign_lo", m.lo, 42);
    check("ign_hi", m.hi, 0);

    m_hi = m.hi === 32'd0 ? 32'd0 : 32'hDEAD;
    m_lo = 32'd42;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        dmd;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      dmd = 1'($urandom_range(0, 1));
      model(op, a, b, mcyc);
      run_op(op, a, b, dmd, cyc, sbad);
      check($sformatf("rnd%0d_cyc op%0d", i, op), cyc, mcyc);
      check($sformatf("rnd%0d_hi op%0d", i, op), m.hi, m_hi);
      check($sformatf("rnd%0d_lo op%0d", i, op), m.lo, m_lo);
      check($sformatf("rnd%0d_stall", i), sbad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
